// File: rtl/lfsr_pkg.sv
// Shared types and default tap masks for the LFSR random word generator.
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } lfsr_fsm_e;

    // Maximal-length tap masks for common widths (bit k set = state bit k feeds the XOR).
    localparam logic [3:0]  LFSR_TAPS_4  = 4'hC;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

    function automatic int unsigned step_cnt_width(input int unsigned out_w);
        return $clog2(out_w + 1);
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR state register with feedback XOR, step enable and parallel load.
// With LFSR_ZERO_GUARD_EN defined, a zero load value is replaced by SEED.
module lfsr_core #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_en_i,
    input  logic             load_en_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] state_o,
    output logic             fb_o
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] load_val;

    assign fb_o    = ^(state_q & TAPS);
    assign state_o = state_q;

`ifdef LFSR_ZERO_GUARD_EN
    assign load_val = (load_val_i == '0) ? SEED : load_val_i;
`else
    assign load_val = load_val_i;
`endif

    always_comb begin
        state_d = state_q;
        if (load_en_i) begin
            state_d = load_val;
        end else if (step_en_i) begin
            state_d = {state_q[WIDTH-2:0], fb_o};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/lfsr_random_gen.sv
// LFSR random word generator: IDLE/SHIFT/HOLD FSM collecting OUT_W feedback bits per word.
// Optional LFSR_ZERO_GUARD_EN macro makes a zero seed load fall back to SEED.
module lfsr_random_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_16,
    parameter int unsigned      OUT_W = 8,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             start,
    input  logic             rnd_ready,
    output logic             rnd_valid,
    output logic [OUT_W-1:0] rnd_data,
    output logic             busy,
    output logic [WIDTH-1:0] state_o
);

    localparam int unsigned      CNT_W    = step_cnt_width(OUT_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);

    lfsr_fsm_e        fsm_q;
    logic [CNT_W-1:0] cnt_q;
    logic [OUT_W-1:0] data_q;
    logic [OUT_W-1:0] data_d;
    logic             valid_q;
    logic             busy_q;

    logic             fb;
    logic             step_en;
    logic             load_en;
    logic             hshake;

    assign hshake  = valid_q & rnd_ready;
    assign step_en = (fsm_q == ST_SHIFT);
    // Load is honoured in IDLE, and in HOLD only while the word is not being taken.
    assign load_en = load & ((fsm_q == ST_IDLE) | ((fsm_q == ST_HOLD) & ~hshake));

    generate
        if (OUT_W == 1) begin : g_single
            assign data_d = fb;
        end else begin : g_multi
            assign data_d = {data_q[OUT_W-2:0], fb};
        end
    endgenerate

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .step_en_i  (step_en),
        .load_en_i  (load_en),
        .load_val_i (seed_in),
        .state_o    (state_o),
        .fb_o       (fb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q   <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (!load && start) begin
                        fsm_q  <= ST_SHIFT;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    data_q <= data_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        fsm_q   <= ST_HOLD;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (hshake) begin
                        valid_q <= 1'b0;
                        if (start) begin
                            fsm_q  <= ST_SHIFT;
                            cnt_q  <= '0;
                            busy_q <= 1'b1;
                        end else begin
                            fsm_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    fsm_q   <= ST_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rnd_valid = valid_q;
    assign rnd_data  = data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_lfsr_random_gen.sv
// Directed bench for lfsr_random_gen: 4-bit LFSR with 4-bit words and with 1-bit words.
module tb_lfsr_random_gen;

    logic       clk = 1'b0;
    logic       reset;

    logic       load_a, start_a, ready_a;
    logic [3:0] seed_a;
    logic       valid_a, busy_a;
    logic [3:0] data_a, state_a;

    logic       load_b, start_b, ready_b;
    logic [3:0] seed_b;
    logic       valid_b, busy_b;
    logic [0:0] data_b;
    logic [3:0] state_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lfsr_random_gen #(.WIDTH(4), .TAPS(4'hC), .OUT_W(4), .SEED(4'h1)) u_dut_a (
        .clk(clk), .reset(reset), .load(load_a), .seed_in(seed_a), .start(start_a),
        .rnd_ready(ready_a), .rnd_valid(valid_a), .rnd_data(data_a), .busy(busy_a),
        .state_o(state_a)
    );

    lfsr_random_gen #(.WIDTH(4), .TAPS(4'hC), .OUT_W(1), .SEED(4'h1)) u_dut_b (
        .clk(clk), .reset(reset), .load(load_b), .seed_in(seed_b), .start(start_b),
        .rnd_ready(ready_b), .rnd_valid(valid_b), .rnd_data(data_b), .busy(busy_b),
        .state_o(state_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy_a got=%b want=0", busy_a); end
        total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL reset_valid_a got=%b want=0", valid_a); end
        total++; if (data_a !== 4'h0) begin bad++; $display("FAIL reset_data_a got=%h want=0", data_a); end
        total++; if (state_a !== 4'h1) begin bad++; $display("FAIL reset_state_a got=%h want=1", state_a); end
        total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL reset_busy_b got=%b want=0", busy_b); end
        total++; if (valid_b !== 1'b0) begin bad++; $display("FAIL reset_valid_b got=%b want=0", valid_b); end
        total++; if (state_b !== 4'h1) begin bad++; $display("FAIL reset_state_b got=%h want=1", state_b); end
    endtask

    task automatic test_single_word();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", busy_a); end
        repeat (3) tick();
        total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b want=0", valid_a); end
        tick();
        total++; if (valid_a !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", valid_a); end
        total++; if (data_a !== 4'b0011) begin bad++; $display("FAIL single_data got=%b want=0011", data_a); end
        total++; if (state_a !== 4'b0011) begin bad++; $display("FAIL single_state got=%b want=0011", state_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL single_busy_hold got=%b want=0", busy_a); end
    endtask

    task automatic test_hold_stable();
        logic [3:0] exp_state;
        exp_state = 4'b0011;
        for (int i = 0; i < 10; i++) begin
            start_a = i[0];
            load_a  = (i == 3) || (i == 7);
            seed_a  = (i == 3) ? 4'hA : 4'h6;
            tick();
            if (load_a) exp_state = seed_a;
            total++; if (valid_a !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d] got=%b want=1", i, valid_a); end
            total++; if (data_a !== 4'b0011) begin bad++; $display("FAIL hold_data[%0d] got=%b want=0011", i, data_a); end
            total++; if (state_a !== exp_state) begin bad++; $display("FAIL hold_state[%0d] got=%h want=%h", i, state_a, exp_state); end
        end
        load_a  = 1'b0;
        start_a = 1'b0;
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL hold_release_valid got=%b want=0", valid_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL hold_release_busy got=%b want=0", busy_a); end
        total++; if (data_a !== 4'b0011) begin bad++; $display("FAIL hold_release_data got=%b want=0011", data_a); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        repeat (3) tick();
        total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL b2b_early1 got=%b want=0", valid_a); end
        tick();
        total++; if (valid_a !== 1'b1) begin bad++; $display("FAIL b2b_valid1 got=%b want=1", valid_a); end
        total++; if (data_a !== 4'b0011) begin bad++; $display("FAIL b2b_data1 got=%b want=0011", data_a); end
        tick();
        total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL b2b_drop got=%b want=0", valid_a); end
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b want=1", busy_a); end
        repeat (3) tick();
        total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL b2b_early2 got=%b want=0", valid_a); end
        tick();
        total++; if (valid_a !== 1'b1) begin bad++; $display("FAIL b2b_valid2 got=%b want=1", valid_a); end
        total++; if (data_a !== 4'b0101) begin bad++; $display("FAIL b2b_data2 got=%b want=0101", data_a); end
        total++; if (state_a !== 4'b0101) begin bad++; $display("FAIL b2b_state2 got=%b want=0101", state_a); end
        start_a = 1'b0;
        tick();
        ready_a = 1'b0;
        total++; if (valid_a !== 1'b0 || busy_a !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b%b want=00", valid_a, busy_a); end
    endtask

    task automatic test_load_zero();
        logic [3:0] exp_seed, exp_word;
`ifdef LFSR_ZERO_GUARD_EN
        exp_seed = 4'b0001;
        exp_word = 4'b0011;
`else
        exp_seed = 4'b0000;
        exp_word = 4'b0000;
`endif
        load_a = 1'b1;
        seed_a = 4'h0;
        tick();
        load_a = 1'b0;
        total++; if (state_a !== exp_seed) begin bad++; $display("FAIL zero_load_state got=%b want=%b", state_a, exp_seed); end
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (4) tick();
        total++; if (valid_a !== 1'b1) begin bad++; $display("FAIL zero_valid got=%b want=1", valid_a); end
        total++; if (data_a !== exp_word) begin bad++; $display("FAIL zero_data got=%b want=%b", data_a, exp_word); end
        total++; if (state_a !== exp_word) begin bad++; $display("FAIL zero_state got=%b want=%b", state_a, exp_word); end
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        load_a  = 1'b1;
        start_a = 1'b1;
        seed_a  = 4'h9;
        tick();
        load_a  = 1'b0;
        start_a = 1'b0;
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL load_start_busy got=%b want=0", busy_a); end
        total++; if (state_a !== 4'h9) begin bad++; $display("FAIL load_start_state got=%h want=9", state_a); end
        tick();
        total++; if (busy_a !== 1'b0 || valid_a !== 1'b0) begin bad++; $display("FAIL load_start_idle got=%b%b want=00", busy_a, valid_a); end
    endtask

    task automatic test_reset_midshift();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy_a); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b want=0", busy_a); end
        total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", valid_a); end
        total++; if (data_a !== 4'h0) begin bad++; $display("FAIL mid_rst_data got=%h want=0", data_a); end
        total++; if (state_a !== 4'h1) begin bad++; $display("FAIL mid_rst_state got=%h want=1", state_a); end
        repeat (5) tick();
        total++; if (busy_a !== 1'b0 || valid_a !== 1'b0) begin bad++; $display("FAIL mid_rst_stay got=%b%b want=00", busy_a, valid_a); end
    endtask

    task automatic test_full_period();
        logic [3:0] tbl [15];
        int n;
        tbl = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010, 4'b0101,
                4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001};
        start_b = 1'b1;
        ready_b = 1'b1;
        tick();
        for (int k = 0; k < 15; k++) begin
            n = 0;
            while (valid_b !== 1'b1 && n < 4) begin
                tick();
                n++;
            end
            total++; if (valid_b !== 1'b1) begin bad++; $display("FAIL period_timeout[%0d] got=%b want=1", k, valid_b); end
            total++; if (state_b !== tbl[k]) begin bad++; $display("FAIL period_state[%0d] got=%b want=%b", k, state_b, tbl[k]); end
            total++; if (data_b !== tbl[k][0]) begin bad++; $display("FAIL period_data[%0d] got=%b want=%b", k, data_b, tbl[k][0]); end
            if (k == 14) start_b = 1'b0;
            tick();
        end
        ready_b = 1'b0;
        total++; if (busy_b !== 1'b0 || valid_b !== 1'b0) begin bad++; $display("FAIL period_idle got=%b%b want=00", busy_b, valid_b); end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset   = 1'b0;
        load_a  = 1'b0; start_a = 1'b0; ready_a = 1'b0; seed_a = 4'h0;
        load_b  = 1'b0; start_b = 1'b0; ready_b = 1'b0; seed_b = 4'h0;
        tick();
        test_reset();
        test_single_word();
        test_hold_stable();
        test_back_to_back();
        test_load_zero();
        test_reset_midshift();
        test_full_period();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
